// File: rtl/alu_sched_if.sv
// alu_sched_if: requester, ALU issue/return and response signals of the alu_sched block.
// master = environment (requesters, ALU, response consumer); slave = scheduler.
interface alu_sched_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   REQ_VLD;
  logic [NREQ-1:0]   REQ_RDY;
  logic [2*NREQ-1:0] REQ_OP;
  logic [8*NREQ-1:0] REQ_A;
  logic [8*NREQ-1:0] REQ_B;
  logic              VLD;
  logic [1:0]        OP;
  logic [7:0]        A;
  logic [7:0]        B;
  logic [15:0]       OUT;
  logic              OV;
  logic              RSP_VLD;
  logic              RSP_RDY;
  logic [IDW-1:0]    RSP_ID;
  logic [15:0]       RSP_DATA;
  logic              RSP_OV;

  modport master (
    output REQ_VLD, REQ_OP, REQ_A, REQ_B, OUT, OV, RSP_RDY,
    input  REQ_RDY, VLD, OP, A, B, RSP_VLD, RSP_ID, RSP_DATA, RSP_OV
  );

  modport slave (
    input  REQ_VLD, REQ_OP, REQ_A, REQ_B, OUT, OV, RSP_RDY,
    output REQ_RDY, VLD, OP, A, B, RSP_VLD, RSP_ID, RSP_DATA, RSP_OV
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: shares one pipelined ALU among NREQ requesters with credit-gated in-order responses.
// Define ALU_SCHED_STRICT_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module alu_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ALU_LAT   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input logic        CLK,
  input logic        RST_N,
  alu_sched_if.slave bus
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TD  = ALU_LAT + 1;
  localparam int unsigned PW  = $clog2(RSP_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned SW  = $clog2(RSP_DEPTH + TD + 1) + 1;

  logic [NREQ-1:0] gnt_c;
  logic [NREQ-1:0] vld_hi_c;
  logic [NREQ-1:0] cand_c;
  logic            acc_c;
  logic [IDW-1:0]  gidx_c;
  logic [1:0]      sel_op_c;
  logic [7:0]      sel_a_c;
  logic [7:0]      sel_b_c;
  logic [SW-1:0]   inflight_c;
  logic            cred_ok_c;
  logic            push_c;
  logic            pop_c;

  logic            vld_q, vld_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [TD-1:0]   tag_vld_q, tag_vld_d;
  logic [IDW-1:0]  tag_id_q [TD];
  logic [IDW-1:0]  tag_id_d [TD];
  logic [IDW-1:0]  fifo_id_q [RSP_DEPTH];
  logic [IDW-1:0]  fifo_id_d [RSP_DEPTH];
  logic [15:0]     fifo_data_q [RSP_DEPTH];
  logic [15:0]     fifo_data_d [RSP_DEPTH];
  logic            fifo_ov_q [RSP_DEPTH];
  logic            fifo_ov_d [RSP_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

`ifndef ALU_SCHED_STRICT_PRIO_EN
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  // Credit check and grant selection; a grant is only offered while a FIFO slot is reserved.
  always_comb begin
    inflight_c = '0;
    for (int k = 0; k < TD; k++) inflight_c = inflight_c + SW'(tag_vld_q[k]);
    cred_ok_c = (inflight_c + SW'(cnt_q)) < SW'(RSP_DEPTH);

    vld_hi_c = bus.REQ_VLD;
`ifndef ALU_SCHED_STRICT_PRIO_EN
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) < rr_ptr_q) vld_hi_c[j] = 1'b0;
    end
`endif
    cand_c = (|vld_hi_c) ? vld_hi_c : bus.REQ_VLD;

    acc_c    = 1'b0;
    gidx_c   = '0;
    sel_op_c = '0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (cred_ok_c && !acc_c && cand_c[j]) begin
        acc_c    = 1'b1;
        gidx_c   = IDW'(j);
        sel_op_c = bus.REQ_OP[2*j +: 2];
        sel_a_c  = bus.REQ_A[8*j +: 8];
        sel_b_c  = bus.REQ_B[8*j +: 8];
      end
    end

    gnt_c = '0;
    for (int j = 0; j < NREQ; j++) gnt_c[j] = acc_c && (gidx_c == IDW'(j));
  end

  assign bus.REQ_RDY = gnt_c;

  // Issue registers, tag pipeline and response FIFO next state.
  always_comb begin
    vld_d = acc_c;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    if (acc_c) begin
      op_d = sel_op_c;
      a_d  = sel_a_c;
      b_d  = sel_b_c;
    end

    tag_vld_d   = {tag_vld_q[TD-2:0], acc_c};
    tag_id_d[0] = gidx_c;
    for (int k = 1; k < TD; k++) tag_id_d[k] = tag_id_q[k-1];

    push_c      = tag_vld_q[TD-1];
    pop_c       = (cnt_q != '0) && bus.RSP_RDY;
    fifo_id_d   = fifo_id_q;
    fifo_data_d = fifo_data_q;
    fifo_ov_d   = fifo_ov_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push_c) begin
      fifo_id_d[wr_ptr_q]   = tag_id_q[TD-1];
      fifo_data_d[wr_ptr_q] = bus.OUT;
      fifo_ov_d[wr_ptr_q]   = bus.OV;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q     <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k < TD; k++) tag_id_q[k] <= '0;
      for (int e = 0; e < RSP_DEPTH; e++) begin
        fifo_id_q[e]   <= '0;
        fifo_data_q[e] <= '0;
        fifo_ov_q[e]   <= 1'b0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      vld_q       <= vld_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      fifo_id_q   <= fifo_id_d;
      fifo_data_q <= fifo_data_d;
      fifo_ov_q   <= fifo_ov_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifndef ALU_SCHED_STRICT_PRIO_EN
  // Search restarts just past the most recent winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (acc_c) rr_ptr_d = (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign bus.VLD      = vld_q;
  assign bus.OP       = op_q;
  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.RSP_VLD  = (cnt_q != '0);
  assign bus.RSP_ID   = fifo_id_q[rd_ptr_q];
  assign bus.RSP_DATA = fifo_data_q[rd_ptr_q];
  assign bus.RSP_OV   = fifo_ov_q[rd_ptr_q];
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_alu_sched;
  localparam int unsigned NREQ      = 4;
  localparam int unsigned ALU_LAT   = 2;
  localparam int unsigned RSP_DEPTH = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  alu_sched_if #(.NREQ(NREQ)) bus ();

  alu_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ALU behaviour: {ov, result}
  function automatic logic [16:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic        ov;
    case (op)
      2'd0:    begin r = 16'(a) + 16'(b); ov = r[8];      end
      2'd1:    begin r = 16'(a) - 16'(b); ov = (a < b);   end
      2'd2:    begin r = 16'(a) * 16'(b); ov = |r[15:8];  end
      default: begin r = {8'h00, a ^ b};  ov = 1'b0;      end
    endcase
    return {ov, r};
  endfunction

  // ALU environment: fixed latency, junk on idle slots
  logic [16:0] alu_pipe [ALU_LAT];
  always @(posedge CLK) begin
    alu_pipe[0] <= bus.VLD ? alu_f(bus.OP, bus.A, bus.B) : 17'($urandom);
    for (int k = 1; k < ALU_LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign bus.OUT = alu_pipe[ALU_LAT-1][15:0];
  assign bus.OV  = alu_pipe[ALU_LAT-1][16];

  // Transaction model: every issued-but-unpopped op, visible at the head once its due cycle arrives
  typedef struct {
    int          id;
    logic [15:0] data;
    logic        ov;
    longint      due;
  } rsp_t;

  rsp_t        mq[$];
  int          m_rr  = 0;
  logic        m_vld = 1'b0;
  logic [1:0]  m_op  = '0;
  logic [7:0]  m_a   = '0;
  logic [7:0]  m_b   = '0;
  longint      cyc   = 0;

  always @(negedge CLK) begin : cmp
    int              g;
    int              j;
    bit              hv;
    logic [NREQ-1:0] exp_rdy;
    logic [16:0]     r;
    hv = 1'b0;
    if (!RST_N) begin
      mq.delete();
      m_rr = 0; m_vld = 1'b0; m_op = '0; m_a = '0; m_b = '0;
      chk("rst_vld", 32'(bus.VLD), 32'd0);
      chk("rst_op", 32'(bus.OP), 32'd0);
      chk("rst_a", 32'(bus.A), 32'd0);
      chk("rst_b", 32'(bus.B), 32'd0);
      chk("rst_rsp_vld", 32'(bus.RSP_VLD), 32'd0);
      chk("rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
      chk("rst_rsp_data", 32'(bus.RSP_DATA), 32'd0);
      chk("rst_rsp_ov", 32'(bus.RSP_OV), 32'd0);
    end else begin
      chk("vld", 32'(bus.VLD), 32'(m_vld));
      chk("op", 32'(bus.OP), 32'(m_op));
      chk("a", 32'(bus.A), 32'(m_a));
      chk("b", 32'(bus.B), 32'(m_b));
      hv = (mq.size() > 0) && (mq[0].due <= cyc);
      chk("rsp_vld", 32'(bus.RSP_VLD), 32'(hv));
      if (hv) begin
        chk("rsp_id", 32'(bus.RSP_ID), 32'(mq[0].id));
        chk("rsp_data", 32'(bus.RSP_DATA), 32'(mq[0].data));
        chk("rsp_ov", 32'(bus.RSP_OV), 32'(mq[0].ov));
      end
    end

    g = -1;
    if (mq.size() < int'(RSP_DEPTH)) begin
      for (int i = 0; i < int'(NREQ); i++) begin
`ifdef ALU_SCHED_STRICT_PRIO_EN
        j = i;
`else
        j = (m_rr + i) % int'(NREQ);
`endif
        if (g < 0 && bus.REQ_VLD[j]) g = j;
      end
    end
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_rdy", 32'(bus.REQ_RDY), 32'(exp_rdy));
    chk("no_push_full", 32'(dut.push_c && (int'(dut.cnt_q) == int'(RSP_DEPTH))), 32'd0);

    if (RST_N) begin
      if (hv && bus.RSP_RDY) void'(mq.pop_front());
      if (g >= 0) begin
        m_vld = 1'b1;
        m_op  = 2'(bus.REQ_OP >> (2 * g));
        m_a   = 8'(bus.REQ_A >> (8 * g));
        m_b   = 8'(bus.REQ_B >> (8 * g));
        r     = alu_f(m_op, m_a, m_b);
        mq.push_back('{g, r[15:0], r[16], cyc + 2 + longint'(ALU_LAT)});
        m_rr  = (g + 1) % int'(NREQ);
      end else begin
        m_vld = 1'b0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.REQ_VLD = '0;
    bus.REQ_OP  = '0;
    bus.REQ_A   = '0;
    bus.REQ_B   = '0;
    bus.RSP_RDY = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.REQ_VLD[i]       = 1'b1;
    bus.REQ_OP[2*i +: 2] = op;
    bus.REQ_A[8*i +: 8]  = a;
    bus.REQ_B[8*i +: 8]  = b;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int gi;
    int gl [8];
    int rid [3];
    logic [15:0] rdat [3];
    logic rov [3];

    drive_idle();

    // single request from requester 2
    do_reset();
    drive_idle();
    set_req(2, 2'd0, 8'h10, 8'h05);
    @(negedge CLK);
    chk("t1_rdy", 32'(bus.REQ_RDY), 32'h4);
    step();
    bus.REQ_VLD = '0;
    @(negedge CLK);
    chk("t1_vld", 32'(bus.VLD), 32'd1);
    chk("t1_a", 32'(bus.A), 32'h10);
    chk("t1_b", 32'(bus.B), 32'h05);
    step();
    @(negedge CLK);
    chk("t1_rsp_early2", 32'(bus.RSP_VLD), 32'd0);
    step();
    @(negedge CLK);
    chk("t1_rsp_early3", 32'(bus.RSP_VLD), 32'd0);
    step();
    @(negedge CLK);
    chk("t1_rsp_vld", 32'(bus.RSP_VLD), 32'd1);
    chk("t1_rsp_id", 32'(bus.RSP_ID), 32'd2);
    chk("t1_rsp_data", 32'(bus.RSP_DATA), 32'h0015);
    step();

    // fairness with all requesters held
    do_reset();
    drive_idle();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 2'd3, 8'(i), 8'h0F);
    n = 0;
    for (int c = 0; c < 24 && n < 8; c++) begin
      @(negedge CLK);
      if (|bus.REQ_RDY) begin
        gi = 0;
        for (int i = 0; i < int'(NREQ); i++) if (bus.REQ_RDY[i]) gi = i;
        gl[n] = gi;
        n++;
      end
      step();
    end
    chk("t2_count", 32'(n), 32'd8);
    for (int k = 0; k < 8; k++) begin
`ifdef ALU_SCHED_STRICT_PRIO_EN
      chk("t2_order", 32'(gl[k]), 32'd0);
`else
      chk("t2_order", 32'(gl[k]), 32'(k % 4));
`endif
    end
    drive_idle();
    repeat (8) step();

    // backpressure: credits run out, one pop frees exactly one issue
    do_reset();
    drive_idle();
    bus.RSP_RDY = 1'b0;
    set_req(1, 2'd0, 8'h01, 8'h01);
    n = 0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.REQ_RDY[1]) n++;
      step();
    end
    chk("t3_accepts", 32'(n), 32'd4);
    @(negedge CLK);
    chk("t3_rdy_off", 32'(bus.REQ_RDY), 32'd0);
    step();
    bus.RSP_RDY = 1'b1;
    step();
    bus.RSP_RDY = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.REQ_RDY[1]) n++;
      step();
    end
    chk("t3_extra_accepts", 32'(n), 32'd1);
    drive_idle();
    repeat (10) step();

    // ordering and overflow flag
    do_reset();
    drive_idle();
    set_req(3, 2'd0, 8'h01, 8'h02);
    step();
    bus.REQ_VLD = '0;
    set_req(0, 2'd2, 8'hF0, 8'h10);
    step();
    bus.REQ_VLD = '0;
    set_req(1, 2'd3, 8'h55, 8'h0F);
    step();
    bus.REQ_VLD = '0;
    n = 0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.RSP_VLD && bus.RSP_RDY && n < 3) begin
        rid[n] = int'(bus.RSP_ID); rdat[n] = bus.RSP_DATA; rov[n] = bus.RSP_OV;
        n++;
      end
      step();
    end
    chk("t4_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("t4_id0", 32'(rid[0]), 32'd3);
      chk("t4_id1", 32'(rid[1]), 32'd0);
      chk("t4_id2", 32'(rid[2]), 32'd1);
      chk("t4_data0", 32'(rdat[0]), 32'h0003);
      chk("t4_data1", 32'(rdat[1]), 32'h0F00);
      chk("t4_data2", 32'(rdat[2]), 32'h005A);
      chk("t4_ov0", 32'(rov[0]), 32'd0);
      chk("t4_ov1", 32'(rov[1]), 32'd1);
      chk("t4_ov2", 32'(rov[2]), 32'd0);
    end

    // reset with ops in flight and buffered
    do_reset();
    drive_idle();
    bus.RSP_RDY = 1'b0;
    set_req(0, 2'd0, 8'h01, 8'h01);
    set_req(2, 2'd1, 8'h09, 8'h03);
    repeat (6) step();
    @(negedge CLK);
    chk("t5_buffered", 32'(bus.RSP_VLD), 32'd1);
    step();
    RST_N = 1'b0;
    @(negedge CLK);
    chk("t5_rst_rdy", 32'(bus.REQ_RDY & 4'b0000), 32'd0);
    chk("t5_rst_rsp_vld", 32'(bus.RSP_VLD), 32'd0);
    step();
    RST_N = 1'b1;
    bus.REQ_VLD = '0;
    bus.RSP_RDY = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      chk("t5_no_rsp", 32'(bus.RSP_VLD), 32'd0);
      chk("t5_no_vld", 32'(bus.VLD), 32'd0);
      step();
    end
    set_req(3, 2'd0, 8'h20, 8'h22);
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.REQ_VLD = '0;
      @(negedge CLK);
      chk("t5_latency", 32'(bus.RSP_VLD), 32'(k == 4));
    end
    chk("t5_id", 32'(bus.RSP_ID), 32'd3);
    chk("t5_data", 32'(bus.RSP_DATA), 32'h0042);
    step();

    // head holds steady under backpressure
    do_reset();
    drive_idle();
    bus.RSP_RDY = 1'b0;
    set_req(1, 2'd1, 8'h03, 8'h05);
    step();
    bus.REQ_VLD = '0;
    step(); step(); step();
    repeat (5) begin
      @(negedge CLK);
      chk("t6_hold_vld", 32'(bus.RSP_VLD), 32'd1);
      chk("t6_hold_id", 32'(bus.RSP_ID), 32'd1);
      chk("t6_hold_data", 32'(bus.RSP_DATA), 32'hFFFE);
      chk("t6_hold_ov", 32'(bus.RSP_OV), 32'd1);
      step();
    end
    bus.RSP_RDY = 1'b1;
    step();
    bus.RSP_RDY = 1'b0;
    @(negedge CLK);
    chk("t6_popped", 32'(bus.RSP_VLD), 32'd0);
    step();

    // randomized traffic with occasional resets
    do_reset();
    drive_idle();
    repeat (3000) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        bus.REQ_VLD[i]       = ($urandom_range(0, 1) == 1);
        bus.REQ_OP[2*i +: 2] = 2'($urandom);
        bus.REQ_A[8*i +: 8]  = 8'($urandom);
        bus.REQ_B[8*i +: 8]  = 8'($urandom);
      end
      bus.RSP_RDY = ($urandom_range(0, 3) != 0);
      RST_N       = ($urandom_range(0, 199) != 0);
      step();
    end
    RST_N = 1'b1;
    drive_idle();
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
